spi_master_arbiter: RTL and testbench

- Shares one SPI master controller between NUM_REQ byte-transfer requesters using round-robin arbitration.
- Sequences each transfer: launches the master, waits for completion or timeout, then returns the received byte to the owning requester.
- Exports a one-hot grant vector so the owner can be used downstream for chip-select routing.
- Sits between client blocks and the SPI master controller's start/tx_data/rx_data/busy/done handshake.

---
 rtl/spi_master_arbiter.sv | 164 ++++++++++++++++
 tb/tb_spi_master_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter that shares one SPI master controller between NUM_REQ
// byte-transfer requesters, with a completion watchdog and one-hot grant export.
module spi_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     ack,
  output logic [7:0]             rsp_data,
  output logic                   rsp_err,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   m_start,
  output logic [7:0]             m_tx_data,
  input  logic                   m_busy,
  input  logic                   m_done,
  input  logic [7:0]             m_rx_data
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] CNT_LAST = TO_EN ? CW'(TIMEOUT_CYCLES - 1) : {CW{1'b0}};
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [7:0]           rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 m_start_q, m_start_d;
  logic [7:0]           m_tx_data_q, m_tx_data_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]        sel_q, sel_d;

  logic [IW-1:0]        sel_s;
  logic [7:0]           tx_s;
  logic                 hit_s;

  // Round-robin pick: scan offsets from farthest to nearest so the first set bit
  // after rr_ptr overrides any later candidate.
  always_comb begin
    sel_s = rr_ptr_q;
    hit_s = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        hit_s = req[i] && (i == ((int'(rr_ptr_q) + k) % NUM_REQ));
        sel_s = hit_s ? IW'(i) : sel_s;
      end
    end
  end

  // Byte of the selected requester.
  always_comb begin
    tx_s = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      tx_s = (sel_s == IW'(i)) ? req_data[8*i +: 8] : tx_s;
    end
  end

  // Next-state and next-output computation for the transfer sequencer.
  always_comb begin
    state_d     = state_q;
    ack_d       = {NUM_REQ{1'b0}};
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    grant_d     = grant_q;
    m_start_d   = 1'b0;
    m_tx_data_d = m_tx_data_q;
    cnt_d       = cnt_q;
    rr_ptr_d    = rr_ptr_q;
    sel_d       = sel_q;
    case (state_q)
      IDLE: begin
        if ((|req) && !m_busy) begin
          sel_d       = sel_s;
          grant_d     = ONE << sel_s;
          m_tx_data_d = tx_s;
          m_start_d   = 1'b1;
          state_d     = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        cnt_d   = {CW{1'b0}};
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // A completion in the final watchdog cycle still counts as success.
        if (m_done) begin
          rsp_data_d = m_rx_data;
          rsp_err_d  = 1'b0;
          ack_d      = grant_q;
          state_d    = RESP;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          rsp_data_d = 8'h00;
          rsp_err_d  = 1'b1;
          ack_d      = grant_q;
          state_d    = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        rr_ptr_d   = sel_q;
        grant_d    = {NUM_REQ{1'b0}};
        rsp_data_d = 8'h00;
        rsp_err_d  = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        grant_d = {NUM_REQ{1'b0}};
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ack_q       <= {NUM_REQ{1'b0}};
      rsp_data_q  <= 8'h00;
      rsp_err_q   <= 1'b0;
      grant_q     <= {NUM_REQ{1'b0}};
      m_start_q   <= 1'b0;
      m_tx_data_q <= 8'h00;
      cnt_q       <= {CW{1'b0}};
      rr_ptr_q    <= IW'(NUM_REQ - 1);
      sel_q       <= {IW{1'b0}};
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      grant_q     <= grant_d;
      m_start_q   <= m_start_d;
      m_tx_data_q <= m_tx_data_d;
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      sel_q       <= sel_d;
    end
  end

  assign ack       = ack_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign grant     = grant_q;
  assign m_start   = m_start_q;
  assign m_tx_data = m_tx_data_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Scoreboard bench for spi_master_arbiter: stimulus queues expected start and
// response events; a negedge monitor pops and compares them as the DUT emits them.
module tb_spi_master_arbiter;

  localparam int TO = 32;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic [3:0]  grant;
  logic        m_start;
  logic [7:0]  m_tx_data;
  logic        m_busy;
  logic        m_done;
  logic [7:0]  m_rx_data;

  typedef struct packed { logic [3:0] g; logic [7:0] d; } sexp_t;
  typedef struct packed { logic [3:0] a; logic [7:0] d; logic e; } rexp_t;

  sexp_t sq[$];
  rexp_t rq[$];
  sexp_t mon_s;
  rexp_t mon_r;
  int    n_checks = 0;
  int    n_pass   = 0;

  spi_master_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .ack(ack), .rsp_data(rsp_data), .rsp_err(rsp_err), .grant(grant),
    .m_start(m_start), .m_tx_data(m_tx_data), .m_busy(m_busy),
    .m_done(m_done), .m_rx_data(m_rx_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every start pulse and every ack is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst && m_start === 1'b1) begin
      if (sq.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_start: got grant 0x%0h expected no start", grant);
      end else begin
        mon_s = sq.pop_front();
        chk("start_grant", grant, mon_s.g);
        chk("start_tx", m_tx_data, mon_s.d);
      end
    end
    if (!rst && ack !== 4'b0000) begin
      if (rq.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_ack: got ack 0x%0h expected no ack", ack);
      end else begin
        mon_r = rq.pop_front();
        chk("rsp_ack", ack, mon_r.a);
        chk("rsp_data", rsp_data, mon_r.d);
        chk("rsp_err", rsp_err, mon_r.e);
      end
    end
  end

  task automatic push(input logic [3:0] g, input logic [7:0] tx, input logic [7:0] rx, input logic err);
    sexp_t s;
    rexp_t r;
    s.g = g; s.d = tx;
    r.a = g; r.d = rx; r.e = err;
    sq.push_back(s);
    rq.push_back(r);
  endtask

  // Plays the master side of one transfer and retires the owner's request.
  task automatic serve(input int dly, input logic [7:0] rx, input bit give_done);
    int n;
    n = 0;
    while (m_start !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    chk("start_seen", m_start, 1'b1);
    if (give_done) begin
      repeat (dly) begin @(posedge clk); #1; end
      m_rx_data = rx;
      m_done    = 1'b1;
      @(posedge clk); #1;
      m_done    = 1'b0;
      m_rx_data = 8'h00;
      chk("ack_after_done", ack != 4'b0000, 1'b1);
      n = 0;
      while (ack === 4'b0000 && n < 50) begin @(posedge clk); #1; n++; end
    end else begin
      n = 0;
      while (ack === 4'b0000 && n < TO + 10) begin @(posedge clk); #1; n++; end
      chk("timeout_latency", n, TO + 1);
    end
    req = req & ~ack;
    @(posedge clk); #1;
    chk("grant_clear", grant, 4'b0000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic saw;
    rst       = 1'b1;
    req       = 4'b0000;
    req_data  = {8'h43, 8'hA5, 8'h21, 8'h10};
    m_busy    = 1'b0;
    m_done    = 1'b0;
    m_rx_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ack", ack, 4'b0000);
    chk("reset_grant", grant, 4'b0000);
    chk("reset_m_start", m_start, 1'b0);
    chk("reset_rsp_data", rsp_data, 8'h00);
    chk("reset_rsp_err", rsp_err, 1'b0);
    chk("reset_m_tx_data", m_tx_data, 8'h00);
    rst = 1'b0;
    @(posedge clk); #1;

    // Round robin from reset: 0,1,2,3 then 0,3.
    push(4'b0001, 8'h10, 8'h80, 1'b0);
    push(4'b0010, 8'h21, 8'h81, 1'b0);
    push(4'b0100, 8'hA5, 8'h82, 1'b0);
    push(4'b1000, 8'h43, 8'h83, 1'b0);
    req = 4'b1111;
    serve(3, 8'h80, 1'b1);
    serve(3, 8'h81, 1'b1);
    serve(3, 8'h82, 1'b1);
    serve(3, 8'h83, 1'b1);
    push(4'b0001, 8'h10, 8'h90, 1'b0);
    push(4'b1000, 8'h43, 8'h91, 1'b0);
    req = 4'b1001;
    serve(3, 8'h90, 1'b1);
    serve(3, 8'h91, 1'b1);

    // Single requester, done 20 cycles after start.
    push(4'b0100, 8'hA5, 8'h3C, 1'b0);
    req = 4'b0100;
    serve(20, 8'h3C, 1'b1);

    // Watchdog abort, then a normal transfer.
    push(4'b0001, 8'h10, 8'h00, 1'b1);
    req = 4'b0001;
    serve(0, 8'h00, 1'b0);
    push(4'b0010, 8'h21, 8'h5A, 1'b0);
    req = 4'b0010;
    serve(4, 8'h5A, 1'b1);

    // Done arrives exactly when the counter reaches TO-1.
    push(4'b0100, 8'hA5, 8'h77, 1'b0);
    req = 4'b0100;
    serve(TO, 8'h77, 1'b1);

    // Busy gate.
    m_busy = 1'b1;
    req    = 4'b0010;
    saw    = 1'b0;
    repeat (6) begin @(posedge clk); #1; saw = saw | m_start; end
    chk("busy_gate", saw, 1'b0);
    push(4'b0010, 8'h21, 8'h99, 1'b0);
    m_busy = 1'b0;
    n = 0;
    while (m_start !== 1'b1 && n < 4) begin @(posedge clk); #1; n++; end
    chk("busy_release_start", m_start, 1'b1);
    serve(2, 8'h99, 1'b1);

    // Reset in the middle of WAIT.
    sq.push_back('{g: 4'b1000, d: 8'h43});
    req = 4'b1000;
    n = 0;
    while (m_start !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("midreset_grant", grant, 4'b0000);
    chk("midreset_m_start", m_start, 1'b0);
    chk("midreset_ack", ack, 4'b0000);
    req = 4'b0110;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    push(4'b0010, 8'h21, 8'h5C, 1'b0);
    serve(3, 8'h5C, 1'b1);
    req = 4'b0000;

    repeat (5) begin @(posedge clk); #1; end
    chk("start_queue_empty", sq.size(), 0);
    chk("rsp_queue_empty", rq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
